// File: rtl/uart_cmd_parser.sv
// Frame decoder between the UART receiver and fifo_control: SYNC, CMD, LEN_H, LEN_L[, SUM].
// Define UART_CMD_CHECKSUM_EN for the 5-byte frame with XOR checksum; default is the 4-byte frame.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 5_000_000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        fifo_done,
  output logic [7:0]  cmd,
  output logic [15:0] rx_cnt,
  output logic        cmd_busy,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam int unsigned       TimerW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TimerW-1:0] TimerLast  = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]        ErrTimeout = 2'd2;
  localparam logic [1:0]        ErrCmd     = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StGetCmd,
    StGetLenH,
    StGetLenL,
    StGetSum,
    StHold
  } state_e;

  state_e            state_q;
  logic [7:0]        cmd_sh_q;
  logic [7:0]        len_h_sh_q;
  logic [TimerW-1:0] timer_q;
  logic              last_byte;
  logic              cmd_ok;
  logic [15:0]       len_full;

`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [1:0] ErrSum = 2'd1;
  logic [7:0] len_l_sh_q;
  logic       sum_ok;

  always_comb begin
    last_byte = (state_q == StGetSum);
    len_full  = {len_h_sh_q, len_l_sh_q};
    sum_ok    = ((cmd_sh_q ^ len_h_sh_q ^ len_l_sh_q) == rx_data);
  end
`else
  // Without a SUM byte the low length byte on the wire completes the frame.
  always_comb begin
    last_byte = (state_q == StGetLenL);
    len_full  = {len_h_sh_q, rx_data};
  end
`endif

  always_comb begin
    cmd_ok = (cmd_sh_q == 8'h01) || (cmd_sh_q == 8'h02);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_sh_q   <= '0;
      len_h_sh_q <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      len_l_sh_q <= '0;
`endif
      timer_q    <= '0;
      cmd        <= '0;
      rx_cnt     <= '0;
      cmd_busy   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state_q)
        StIdle: begin
          timer_q <= '0;
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_q <= StGetCmd;
          end
        end
        StHold: begin
          // Bytes arriving here are dropped, even in the release cycle.
          if (fifo_done) begin
            state_q  <= StIdle;
            cmd      <= '0;
            rx_cnt   <= '0;
            cmd_busy <= 1'b0;
          end
        end
        default: begin
          if (rx_valid) begin
            timer_q <= '0;
            if (last_byte) begin
              state_q <= StIdle;
`ifdef UART_CMD_CHECKSUM_EN
              if (!sum_ok) begin
                frame_err <= 1'b1;
                err_code  <= ErrSum;
              end else
`endif
              if (!cmd_ok) begin
                frame_err <= 1'b1;
                err_code  <= ErrCmd;
              end else begin
                state_q  <= StHold;
                cmd      <= cmd_sh_q;
                rx_cnt   <= len_full;
                cmd_busy <= 1'b1;
              end
            end else begin
              case (state_q)
                StGetCmd: begin
                  cmd_sh_q <= rx_data;
                  state_q  <= StGetLenH;
                end
                StGetLenH: begin
                  len_h_sh_q <= rx_data;
                  state_q    <= StGetLenL;
                end
`ifdef UART_CMD_CHECKSUM_EN
                StGetLenL: begin
                  len_l_sh_q <= rx_data;
                  state_q    <= StGetSum;
                end
`endif
                default: state_q <= StIdle;
              endcase
            end
          end else if (timer_q == TimerLast) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            frame_err <= 1'b1;
            err_code  <= ErrTimeout;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
